// File: rtl/color_balls_box.sv
// Colour-ball set collector: det pulses for one cycle once Red, Blue and Green have all been seen.
// Optional macro COLOR_BOX_CLR_ON_INVALID_EN: an invalid code (2'b11) discards partial progress.
module color_balls_box (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in,
    output logic       det
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StR    = 3'd1,
        StB    = 3'd2,
        StG    = 3'd3,
        StRb   = 3'd4,
        StRg   = 3'd5,
        StBg   = 3'd6,
        StDone = 3'd7
    } state_e;

    localparam logic [1:0] ColInvalid = 2'b11;

    state_e     state_q, state_d;
    logic [2:0] seen;      // {green, blue, red} collected in the current state
    logic [2:0] seen_nxt;
    logic [2:0] col_bit;

    function automatic state_e set_to_state(input logic [2:0] s);
        state_e st;
        case (s)
            3'b001:  st = StR;
            3'b010:  st = StB;
            3'b100:  st = StG;
            3'b011:  st = StRb;
            3'b101:  st = StRg;
            3'b110:  st = StBg;
            3'b111:  st = StDone;
            default: st = StIdle;
        endcase
        return st;
    endfunction

    always_comb begin
        seen = 3'b000;
        case (state_q)
            StIdle:  seen = 3'b000;
            StR:     seen = 3'b001;
            StB:     seen = 3'b010;
            StG:     seen = 3'b100;
            StRb:    seen = 3'b011;
            StRg:    seen = 3'b101;
            StBg:    seen = 3'b110;
            StDone:  seen = 3'b111;
            default: seen = 3'b000;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        col_bit  = 3'b001 << in;
        seen_nxt = seen;
        if (state_q == StDone) begin
            // Non-overlapping: the completed set is dropped before adding the new colour.
            if (in == ColInvalid) begin
                state_d = StIdle;
            end else begin
                state_d = set_to_state(col_bit);
            end
        end else if (in == ColInvalid) begin
`ifdef COLOR_BOX_CLR_ON_INVALID_EN
            state_d = StIdle;
`else
            state_d = state_q;
`endif
        end else begin
            seen_nxt = seen | col_bit;
            state_d  = set_to_state(seen_nxt);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign det = (state_q == StDone);

endmodule

// File: tb/tb_color_balls_box.sv
// Directed bench for color_balls_box with a set-based reference model checked every cycle.
module tb_color_balls_box;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] B = 2'b01;
    localparam logic [1:0] G = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] in  = 2'b11;
    logic       det;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model: the set of colours seen, and whether the last edge completed it.
    bit [2:0] m_set  = 3'b000;
    bit       m_done = 1'b0;

    always #5 clk = ~clk;

    color_balls_box dut (
        .clk(clk),
        .rst(rst),
        .in (in),
        .det(det)
    );

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: det=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge rst) begin
        m_set  = 3'b000;
        m_done = 1'b0;
    end

    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_set  = 3'b000;
                m_done = 1'b0;
            end else if (m_done) begin
                m_set  = 3'b000;
                m_done = 1'b0;
                if (in != X) m_set[in] = 1'b1;
            end else if (in == X) begin
`ifdef COLOR_BOX_CLR_ON_INVALID_EN
                m_set = 3'b000;
`endif
            end else begin
                m_set[in] = 1'b1;
                if (m_set == 3'b111) m_done = 1'b1;
            end
            #1;
            check("model", det, m_done);
        end
    end

    task automatic apply(input logic [1:0] col, input logic exp, input string name);
        @(negedge clk);
        in = col;
        @(posedge clk);
        #1;
        check(name, det, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in  = X;
        #1;
        check("reset_det", det, 1'b0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        in  = X;
        repeat (2) @(posedge clk);
        #1;
        check("por_det", det, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // R, G, B
        do_reset();
        apply(R, 1'b0, "rgb_1"); apply(G, 1'b0, "rgb_2"); apply(B, 1'b1, "rgb_3");
        // B, R, G and G, B, R
        do_reset();
        apply(B, 1'b0, "brg_1"); apply(R, 1'b0, "brg_2"); apply(G, 1'b1, "brg_3");
        do_reset();
        apply(G, 1'b0, "gbr_1"); apply(B, 1'b0, "gbr_2"); apply(R, 1'b1, "gbr_3");
        // Repeated colour holds
        do_reset();
        apply(R, 1'b0, "rrr_1"); apply(R, 1'b0, "rrr_2"); apply(R, 1'b0, "rrr_3");
        // Duplicate then complete, then non-overlapping restart from G
        do_reset();
        apply(R, 1'b0, "rgrb_1"); apply(G, 1'b0, "rgrb_2");
        apply(R, 1'b0, "rgrb_3"); apply(B, 1'b1, "rgrb_4");
        apply(G, 1'b0, "restart_1"); apply(R, 1'b0, "restart_2"); apply(B, 1'b1, "restart_3");
        // Invalid out of DONE goes to IDLE
        apply(X, 1'b0, "done_inv"); apply(B, 1'b0, "post_inv_1");
        apply(G, 1'b0, "post_inv_2"); apply(R, 1'b1, "post_inv_3");

        // Mid-collection reset discards R, G
        do_reset();
        apply(R, 1'b0, "mid_rst_1"); apply(G, 1'b0, "mid_rst_2");
        @(negedge clk);
        #2;
        rst = 1'b0;
        in  = X;
        #1;
        check("mid_rst_low", det, 1'b0);
        #9;
        rst = 1'b1;
        apply(B, 1'b0, "mid_rst_b");

        // Async reset while det is high clears it without a clock edge
        do_reset();
        apply(R, 1'b0, "async_1"); apply(G, 1'b0, "async_2"); apply(B, 1'b1, "async_3");
        #1;
        rst = 1'b0;
        #1;
        check("async_clear", det, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Invalid code in the middle of a collection
        do_reset();
        apply(R, 1'b0, "inv_1"); apply(X, 1'b0, "inv_2"); apply(G, 1'b0, "inv_3");
`ifdef COLOR_BOX_CLR_ON_INVALID_EN
        apply(B, 1'b0, "inv_4");
`else
        apply(B, 1'b1, "inv_4");
`endif

        @(negedge clk);
        in = X;
        repeat (2) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
